// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEFAULT_DEPTH = 256;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick; a masked port is treated as not requesting.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic mask_en,
  input  logic mask_id,
  output logic grant_valid,
  output logic grant_id
);

  logic r0;
  logic r1;

  assign r0 = req0 & ~(mask_en & (mask_id == PORT0));
  assign r1 = req1 & ~(mask_en & (mask_id == PORT1));

  assign grant_valid = r0 | r1;
  // On a tie the port that was not served last wins.
  assign grant_id = (r0 & r1) ? ~last : r1;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data memory.
// Optional range check is compiled in with DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rd
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic          last;
  logic          served;
  logic          we_r;
  logic          oob;
  logic          grant_valid;
  logic          grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_oob;

  // In RESP the served port still holds req high, so it is masked out.
  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last        (last),
    .mask_en     (state == RESP),
    .mask_id     (served),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (grant_id == PORT1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  assign sel_oob = RANGE_CHECK & ({1'b0, sel_addr} >= DEPTH_W);

  // Strobes decode from state so an async reset kills a write in flight.
  assign mem_we = (state == ACCESS) &  we_r & ~oob;
  assign mem_re = (state == ACCESS) & ~we_r & ~oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= PORT1;
      served <= PORT0;
      we_r   <= 1'b0;
      oob    <= 1'b0;
      mem_a  <= '0;
      mem_wd <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      err0   <= 1'b0;
      err1   <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant_valid) begin
            served <= grant_id;
            we_r   <= sel_we;
            mem_a  <= sel_addr;
            mem_wd <= sel_wdata;
            oob    <= sel_oob;
            state  <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          last  <= served;
          state <= RESP;
          if (served == PORT0) begin
            ack0   <= 1'b1;
            err0   <= oob;
            rdata0 <= (we_r | oob) ? '0 : mem_rd;
          end else begin
            ack1   <= 1'b1;
            err1   <= oob;
            rdata1 <= (we_r | oob) ? '0 : mem_rd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 256x16 memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] mem_a, mem_wd, mem_rd;
  logic        mem_we, mem_re;

  logic [15:0] ram    [0:255];
  logic [15:0] shadow [0:255];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, re_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  logic        prev_we = 1'b0;
  logic [15:0] we_addr = '0, we_data = '0;

  logic        cw [2];
  logic [15:0] ca [2];
  logic [15:0] cd [2];
  logic [0:0]  exp_q [$];

  always #5 clk = ~clk;

  assign mem_rd = ram[mem_a[7:0]];
  always @(posedge clk) if (mem_we) ram[mem_a[7:0]] = mem_wd;

  dmem_arbiter #(.AW(16), .DW(16), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rd(mem_rd)
  );

  // One clock step: sample just after the edge and keep running strobe checks.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we) begin we_cnt++; we_addr = mem_a; we_data = mem_wd; end
    if (mem_re) re_cnt++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    if (mem_we || mem_re) begin
      checks++;
      if (mem_we && mem_re) begin errors++; $display("FAIL we_re_overlap got we=%0b re=%0b", mem_we, mem_re); end
    end
    if (mem_we) begin
      checks++;
      if (prev_we) begin errors++; $display("FAIL we_two_cycles got consecutive mem_we exp single cycle"); end
    end
    prev_we = mem_we;
  endtask

  task automatic set_req(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic raise_rand(input int p);
    cw[p] = 1'($urandom_range(0, 1));
    ca[p] = 16'($urandom_range(0, 15));
    cd[p] = 16'($urandom);
    set_req(p, cw[p], ca[p], cd[p]);
  endtask

  task automatic apply_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_we = 1'b0;
  endtask

  // Single transaction: raise, wait for ack (bounded), drop, one idle step.
  task automatic run_txn(input int p, input logic w, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic er, output int lat);
    set_req(p, w, a, d);
    lat = -1; rd = '0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = c;
        rd  = (p == 0) ? rdata0 : rdata1;
        er  = (p == 0) ? err0 : err1;
        break;
      end
    end
    drop_req(p);
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({mem_we, mem_re, ack0, ack1, err0, err1} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {mem_we, mem_re, ack0, ack1, err0, err1}); end
    checks++; if (mem_a !== 16'h0)  begin errors++; $display("FAIL reset_mem_a got %h exp 0000", mem_a); end
    checks++; if (mem_wd !== 16'h0) begin errors++; $display("FAIL reset_mem_wd got %h exp 0000", mem_wd); end
    checks++; if (rdata0 !== 16'h0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0000", rdata0); end
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp 0000", rdata1); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [15:0] rd; logic er; int lat;
    int we0c, re0c, a0c, a1c;
    ram[9] = 16'h00A5; shadow[9] = 16'h00A5;
    we0c = we_cnt; re0c = re_cnt; a0c = ack0_cnt; a1c = ack1_cnt;
    run_txn(0, 1'b0, 16'd9, 16'h0, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_read_latency got %0d exp 2", lat); end
    checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL single_read_data got %h exp 00a5", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL single_read_err got %b exp 0", er); end
    checks++; if (re_cnt - re0c !== 1) begin errors++; $display("FAIL single_read_re_cycles got %0d exp 1", re_cnt - re0c); end
    checks++; if (we_cnt - we0c !== 0) begin errors++; $display("FAIL single_read_we_cycles got %0d exp 0", we_cnt - we0c); end
    checks++; if (ack0_cnt - a0c !== 1) begin errors++; $display("FAIL single_read_ack0_pulses got %0d exp 1", ack0_cnt - a0c); end
    checks++; if (ack1_cnt - a1c !== 0) begin errors++; $display("FAIL single_read_ack1_pulses got %0d exp 0", ack1_cnt - a1c); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic er; int lat; int we0c;
    we0c = we_cnt;
    run_txn(1, 1'b1, 16'd3, 16'hBEEF, rd, er, lat);
    shadow[3] = 16'hBEEF;
    checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d exp 2", lat); end
    checks++; if (we_cnt - we0c !== 1) begin errors++; $display("FAIL write_we_cycles got %0d exp 1", we_cnt - we0c); end
    checks++; if (we_addr !== 16'd3) begin errors++; $display("FAIL write_mem_a got %h exp 0003", we_addr); end
    checks++; if (we_data !== 16'hBEEF) begin errors++; $display("FAIL write_mem_wd got %h exp beef", we_data); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL write_rdata got %h exp 0000", rd); end
    run_txn(0, 1'b0, 16'd3, 16'h0, rd, er, lat);
    checks++; if (rd !== shadow[3]) begin errors++; $display("FAIL read_after_write got %h exp %h", rd, shadow[3]); end
  endtask

  task automatic test_contention();
    int left [2];
    int cyc, last_ack;
    logic [15:0] got, expd;
    apply_reset();
    left[0] = 5; left[1] = 5;
    for (int i = 0; i < 10; i++) exp_q.push_back(1'(i % 2));
    raise_rand(0); raise_rand(1);
    cyc = 0; last_ack = -1;
    while ((left[0] > 0 || left[1] > 0) && cyc < 100) begin
      tick(); cyc++;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? ack0 : ack1) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL contention_extra_ack got port %0d exp none", p); end
          else if (exp_q[0] !== 1'(p)) begin errors++; $display("FAIL contention_order got port %0d exp %0d", p, exp_q[0]); end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          checks++;
          if (last_ack < 0 && cyc !== 2) begin errors++; $display("FAIL contention_first_ack got cycle %0d exp 2", cyc); end
          else if (last_ack >= 0 && cyc - last_ack !== 2) begin errors++; $display("FAIL contention_spacing got %0d exp 2", cyc - last_ack); end
          last_ack = cyc;
          got  = (p == 0) ? rdata0 : rdata1;
          expd = cw[p] ? 16'h0 : shadow[ca[p][7:0]];
          if (cw[p]) shadow[ca[p][7:0]] = cd[p];
          checks++; if (got !== expd) begin errors++; $display("FAIL contention_data port %0d got %h exp %h", p, got, expd); end
          drop_req(p);
          left[p]--;
        end else if (!((p == 0) ? req0 : req1) && left[p] > 0) begin
          raise_rand(p);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL contention_timeout got %0d acks missing exp 0", exp_q.size()); end
    exp_q.delete();
    drop_req(0); drop_req(1);
    tick(); tick();
  endtask

  task automatic test_random();
    int left [2], gap [2], raised [2];
    logic pend [2];
    int cyc, lat;
    logic [15:0] got, expd;
    left[0] = 12; left[1] = 12;
    gap[0] = 0; gap[1] = 2;
    pend[0] = 1'b0; pend[1] = 1'b0;
    raised[0] = 0; raised[1] = 0;
    cyc = 0;
    while ((left[0] > 0 || left[1] > 0 || pend[0] || pend[1]) && cyc < 600) begin
      tick(); cyc++;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? ack0 : ack1) begin
          checks++;
          if (!pend[p]) begin errors++; $display("FAIL random_spurious_ack port %0d got ack exp none", p); end
          else begin
            lat = cyc - raised[p];
            checks++; if (lat < 2 || lat > 4) begin errors++; $display("FAIL random_latency port %0d got %0d exp 2..4", p, lat); end
            got  = (p == 0) ? rdata0 : rdata1;
            expd = cw[p] ? 16'h0 : shadow[ca[p][7:0]];
            if (cw[p]) shadow[ca[p][7:0]] = cd[p];
            if (got !== expd) begin errors++; $display("FAIL random_data port %0d got %h exp %h", p, got, expd); end
            left[p]--;
          end
          pend[p] = 1'b0;
          drop_req(p);
          gap[p] = $urandom_range(0, 3);
        end else if (!pend[p] && left[p] > 0) begin
          if (gap[p] == 0) begin raise_rand(p); pend[p] = 1'b1; raised[p] = cyc; end
          else gap[p]--;
        end
      end
    end
    checks++; if (left[0] + left[1] !== 0) begin errors++; $display("FAIL random_timeout got %0d left exp 0", left[0] + left[1]); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    int a0c, a1c, first_port, cyc;
    logic [15:0] got;
    ram[5] = 16'h1234; shadow[5] = 16'h1234;
    ram[7] = 16'h7777; shadow[7] = 16'h7777;
    ram[8] = 16'h8888; shadow[8] = 16'h8888;
    set_req(1, 1'b1, 16'd5, 16'hDEAD);
    tick();
    checks++; if (mem_we !== 1'b1 || mem_a !== 16'd5) begin errors++; $display("FAIL midrst_access got we=%b a=%h exp we=1 a=0005", mem_we, mem_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we_drop got %b exp 0", mem_we); end
    a0c = ack0_cnt; a1c = ack1_cnt;
    tick(); tick();
    drop_req(1);
    checks++; if (ack0_cnt - a0c + ack1_cnt - a1c !== 0) begin errors++; $display("FAIL midrst_no_ack got %0d acks exp 0", ack0_cnt - a0c + ack1_cnt - a1c); end
    checks++; if (ram[5] !== shadow[5]) begin errors++; $display("FAIL midrst_no_write got %h exp %h", ram[5], shadow[5]); end
    rst_n = 1'b1;
    prev_we = 1'b0;
    set_req(0, 1'b0, 16'd7, 16'h0);
    set_req(1, 1'b0, 16'd8, 16'h0);
    first_port = -1;
    cyc = 0;
    while (req1 && cyc < 20) begin
      tick(); cyc++;
      if (ack0) begin
        if (first_port < 0) first_port = 0;
        got = rdata0;
        checks++; if (got !== shadow[7]) begin errors++; $display("FAIL midrst_read0 got %h exp %h", got, shadow[7]); end
        drop_req(0);
      end
      if (ack1) begin
        if (first_port < 0) first_port = 1;
        got = rdata1;
        checks++; if (got !== shadow[8]) begin errors++; $display("FAIL midrst_read1 got %h exp %h", got, shadow[8]); end
        drop_req(1);
      end
    end
    checks++; if (first_port !== 0) begin errors++; $display("FAIL midrst_first_tie got port %0d exp 0", first_port); end
    drop_req(0); drop_req(1);
    tick(); tick();
  endtask

  task automatic test_range();
    logic [15:0] rd, d; logic er; int lat, we0c;
    d = 16'($urandom);
    we0c = we_cnt;
    run_txn(1, 1'b1, 16'h0100, d, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL range_latency got %0d exp 2", lat); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL range_rdata got %h exp 0000", rd); end
`ifdef DMEM_ARB_RANGE_CHECK_EN
    checks++; if (we_cnt - we0c !== 0) begin errors++; $display("FAIL range_we_cycles got %0d exp 0", we_cnt - we0c); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", er); end
`else
    shadow[0] = d;
    checks++; if (we_cnt - we0c !== 1) begin errors++; $display("FAIL range_we_cycles got %0d exp 1", we_cnt - we0c); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL range_err got %b exp 0", er); end
    checks++; if (we_addr !== 16'h0100) begin errors++; $display("FAIL range_mem_a got %h exp 0100", we_addr); end
`endif
    run_txn(0, 1'b0, 16'd0, 16'h0, rd, er, lat);
    checks++; if (rd !== shadow[0]) begin errors++; $display("FAIL range_followup_read got %h exp %h", rd, shadow[0]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      shadow[i] = ram[i];
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_random();
    test_reset_mid_access();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
